// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: redirect/stall control, memory request/response
// channel and the instruction presentation to decode.
interface fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              stall;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [INST_W-1:0] mem_rsp_data;
  logic              inst_valid;
  logic [ADDR_W-1:0] inst_addr;
  logic [INST_W-1:0] inst_data;

  // Fetch controller side
  modport master (
    input  redirect_valid, redirect_pc, stall,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output mem_req_valid, mem_req_addr,
    output inst_valid, inst_addr, inst_data
  );

  // Memory / pipeline side
  modport slave (
    output redirect_valid, redirect_pc, stall,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  mem_req_valid, mem_req_addr,
    input  inst_valid, inst_addr, inst_data
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller: issues one request,
// waits for its response, presents the instruction to decode, and restarts
// the stream on redirects (in-flight responses are discarded via drop).
module fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              inst_valid_q, inst_valid_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic [INST_W-1:0] inst_data_q, inst_data_d;

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_addr_q  <= '0;
      inst_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_addr_q  <= inst_addr_d;
      inst_data_q  <= inst_data_d;
    end
  end

  // Next-state logic: redirect outranks response capture and stall
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_addr_d  = inst_addr_q;
    inst_data_d  = inst_data_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
        end
        if (bus.mem_req_ready) begin
          state_d = WAIT;
          // The accepted request targets the old pc; discard its response.
          drop_d  = bus.redirect_valid;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          if (bus.mem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (bus.mem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_data_d  = bus.mem_rsp_data;
            inst_addr_d  = pc_q;
            pc_d         = pc_q + ADDR_W'(4);
            inst_valid_d = 1'b1;
            state_d      = OUT;
          end
        end
      end
      OUT: begin
        if (bus.redirect_valid) begin
          pc_d         = bus.redirect_pc;
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end else if (!bus.stall) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = pc_q;
  assign bus.inst_valid    = inst_valid_q;
  assign bus.inst_addr     = inst_addr_q;
  assign bus.inst_data     = inst_data_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;
  localparam int unsigned AW  = 64;
  localparam int unsigned IW  = 32;
  localparam logic [63:0] RPC = 64'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

  fetch_ctrl #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(RPC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Stream model: m_nxt is the address of the next instruction in program
  // order; m_out/m_stale track the single in-flight request.
  bit          m_idle, m_out, m_stale, m_present;
  logic [63:0] m_nxt, m_paddr, m_req_addr;
  logic [31:0] m_pdata;

  function automatic bit m_req();
    return !m_idle && !m_out && !m_present;
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h6B8B_4567;
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_present = 1'b0;
    m_nxt = RPC; m_paddr = '0; m_pdata = '0; m_req_addr = '0;
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic tick(input logic rdy, input logic stl, input logic rdv,
                      input logic [63:0] rpc, input logic rv,
                      input logic [31:0] rd);
    bit hs, cap;
    bus.mem_req_ready  = rdy;
    bus.stall          = stl;
    bus.redirect_valid = rdv;
    bus.redirect_pc    = rpc;
    bus.mem_rsp_valid  = rv;
    bus.mem_rsp_data   = rd;
    @(posedge clk);
    if (m_idle) begin
      m_idle = 1'b0;
    end else begin
      hs  = m_req() && rdy;
      cap = m_out && rv && !m_stale && !rdv;
      if (m_out && rv) begin
        m_out = 1'b0; m_stale = 1'b0;
      end else if (m_out && rdv) begin
        m_stale = 1'b1;
      end
      if (hs) begin
        m_out = 1'b1; m_stale = rdv; m_req_addr = m_nxt;
      end
      if (cap) begin
        m_present = 1'b1; m_paddr = m_nxt; m_pdata = rd; m_nxt = m_nxt + 64'd4;
      end else if (m_present && (!stl || rdv)) begin
        m_present = 1'b0;
      end
      if (rdv) m_nxt = rpc;
    end
    #1;
  endtask

  task automatic drive_idle_inputs();
    bus.mem_req_ready = 1'b0; bus.stall = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
  endtask

  task automatic do_reset();
    drive_idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    drive_idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.inst_valid !== 1'b0 || bus.inst_addr !== 64'h0 || bus.inst_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_inst got v=%b a=%h d=%h exp v=0 a=0 d=0", bus.inst_valid, bus.inst_addr, bus.inst_data);
    end
    n_checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== RPC) begin
      n_fail++;
      $display("FAIL reset_req got v=%b a=%h exp v=0 a=%h", bus.mem_req_valid, bus.mem_req_addr, RPC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus.mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_req_valid got %b exp 0", bus.mem_req_valid);
    end
    // Redirect during IDLE is ignored
    tick(1'b1, 1'b0, 1'b1, 64'h500, 1'b0, 32'h0);
    n_checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== RPC) begin
      n_fail++;
      $display("FAIL idle_exit got v=%b a=%h exp v=1 a=%h", bus.mem_req_valid, bus.mem_req_addr, RPC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'(4 * k)) begin
        n_fail++;
        $display("FAIL stream_req[%0d] got v=%b a=%h exp v=1 a=%h", k, bus.mem_req_valid, bus.mem_req_addr, 64'(4 * k));
      end
      tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
      n_checks++;
      if (bus.mem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_wait[%0d] got req=%b iv=%b exp 0 0", k, bus.mem_req_valid, bus.inst_valid);
      end
      tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'h13);
      n_checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_addr !== 64'(4 * k) || bus.inst_data !== 32'h13) begin
        n_fail++;
        $display("FAIL stream_out[%0d] got v=%b a=%h d=%h exp v=1 a=%h d=13", k, bus.inst_valid, bus.inst_addr, bus.inst_data, 64'(4 * k));
      end
      tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
      n_checks++;
      if (bus.inst_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_clear[%0d] got %b exp 0", k, bus.inst_valid);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 32'h13);
      if (k == 0) tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    end
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 32'h0);
      n_checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_addr !== 64'h4 || bus.inst_data !== 32'h13 || bus.mem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got v=%b a=%h d=%h req=%b exp v=1 a=4 d=13 req=0", c, bus.inst_valid, bus.inst_addr, bus.inst_data, bus.mem_req_valid);
      end
    end
    tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    n_checks++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h8) begin
      n_fail++;
      $display("FAIL stall_release got iv=%b req=%b a=%h exp iv=0 req=1 a=8", bus.inst_valid, bus.mem_req_valid, bus.mem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 64'h100, 1'b0, 32'h0);
    n_checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 64'h100 || bus.inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_wait_hold got req=%b a=%h iv=%b exp req=0 a=100 iv=0", bus.mem_req_valid, bus.mem_req_addr, bus.inst_valid);
    end
    tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h13);
    n_checks++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h100) begin
      n_fail++;
      $display("FAIL redir_wait_drop got iv=%b req=%b a=%h exp iv=0 req=1 a=100", bus.inst_valid, bus.mem_req_valid, bus.mem_req_addr);
    end
  endtask

  task automatic test_redirect_rsp();
    tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 64'h200, 1'b1, 32'h13);
    n_checks++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h200) begin
      n_fail++;
      $display("FAIL redir_rsp got iv=%b req=%b a=%h exp iv=0 req=1 a=200", bus.inst_valid, bus.mem_req_valid, bus.mem_req_addr);
    end
  endtask

  task automatic test_redirect_req();
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
      n_checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h200) begin
        n_fail++;
        $display("FAIL req_hold[%0d] got v=%b a=%h exp v=1 a=200", c, bus.mem_req_valid, bus.mem_req_addr);
      end
    end
    tick(1'b0, 1'b0, 1'b1, 64'h40, 1'b0, 32'h0);
    n_checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h40) begin
      n_fail++;
      $display("FAIL req_redir got v=%b a=%h exp v=1 a=40", bus.mem_req_valid, bus.mem_req_addr);
    end
    tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    n_checks++;
    if (bus.mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL req_handshake got v=%b exp 0", bus.mem_req_valid);
    end
    tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h55);
    n_checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_addr !== 64'h40 || bus.inst_data !== 32'h55) begin
      n_fail++;
      $display("FAIL req_redir_out got v=%b a=%h d=%h exp v=1 a=40 d=55", bus.inst_valid, bus.inst_addr, bus.inst_data);
    end
    tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    // Stray response outside WAIT is ignored
    tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'hDEAD);
    n_checks++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h44) begin
      n_fail++;
      $display("FAIL stray_rsp got iv=%b req=%b a=%h exp iv=0 req=1 a=44", bus.inst_valid, bus.mem_req_valid, bus.mem_req_addr);
    end
  endtask

  task automatic test_wrap_and_reset();
    tick(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'h13);
    n_checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_addr !== 64'hFFFF_FFFF_FFFF_FFFC || bus.mem_req_addr !== 64'h0) begin
      n_fail++;
      $display("FAIL wrap_out got v=%b a=%h pc=%h exp v=1 a=fffffffffffffffc pc=0", bus.inst_valid, bus.inst_addr, bus.mem_req_addr);
    end
    tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    n_checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 64'h0) begin
      n_fail++;
      $display("FAIL wrap_next got v=%b a=%h exp v=1 a=0", bus.mem_req_valid, bus.mem_req_addr);
    end
    tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 64'h80, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.inst_valid !== 1'b0 || bus.inst_addr !== 64'h0 || bus.inst_data !== 32'h0 ||
        bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== RPC) begin
      n_fail++;
      $display("FAIL async_reset got iv=%b a=%h d=%h req=%b pc=%h exp all reset values", bus.inst_valid, bus.inst_addr, bus.inst_data, bus.mem_req_valid, bus.mem_req_addr);
    end
    drive_idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'hBAD);
    tick(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 32'hBAD);
    n_checks++;
    if (bus.inst_valid !== 1'b0 || bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== RPC) begin
      n_fail++;
      $display("FAIL restart got iv=%b req=%b a=%h exp iv=0 req=1 a=%h", bus.inst_valid, bus.mem_req_valid, bus.mem_req_addr, RPC);
    end
  endtask

  task automatic test_random();
    logic        rdy, stl, rdv, rv;
    logic [63:0] rpc;
    logic [31:0] rd;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      rdy = ($urandom_range(0, 2) != 0);
      stl = ($urandom_range(0, 2) == 0);
      rdv = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 64'd4;
      else rpc = {$urandom, $urandom} & ~64'h3;
      if (m_out) begin
        rv = ($urandom_range(0, 1) == 1);
        rd = mem_word(m_req_addr);
      end else begin
        rv = ($urandom_range(0, 7) == 0);
        rd = $urandom;
      end
      tick(rdy, stl, rdv, rpc, rv, rd);
      n_checks++;
      if (bus.mem_req_valid !== m_req()) begin
        n_fail++;
        $display("FAIL rnd_req_valid cyc %0d got %b exp %b", cyc, bus.mem_req_valid, m_req());
      end
      n_checks++;
      if (bus.mem_req_addr !== m_nxt) begin
        n_fail++;
        $display("FAIL rnd_req_addr cyc %0d got %h exp %h", cyc, bus.mem_req_addr, m_nxt);
      end
      n_checks++;
      if (bus.inst_valid !== m_present) begin
        n_fail++;
        $display("FAIL rnd_inst_valid cyc %0d got %b exp %b", cyc, bus.inst_valid, m_present);
      end
      if (m_present) begin
        n_checks++;
        if (bus.inst_addr !== m_paddr || bus.inst_data !== m_pdata) begin
          n_fail++;
          $display("FAIL rnd_inst cyc %0d got a=%h d=%h exp a=%h d=%h", cyc, bus.inst_addr, bus.inst_data, m_paddr, m_pdata);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle_inputs();
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp();
    test_redirect_req();
    test_wrap_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 64, fetch address width.
REQ-002 Parameter INST_W, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 redirect_valid  input  1  branch/jump resolved; fetch stream restarts at redirect_pc.
REQ-007 redirect_pc  input  ADDR_W  redirect target address.
REQ-008 stall  input  1  downstream cannot accept the presented instruction.
REQ-009 mem_req_valid  output  1  fetch request valid.
REQ-010 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-011 mem_req_addr  output  ADDR_W  fetch request address.
REQ-012 mem_rsp_valid  input  1  instruction data returned this cycle.
REQ-013 mem_rsp_data  input  INST_W  returned instruction.
REQ-014 inst_valid  output  1  instruction presented to decode.
REQ-015 inst_addr  output  ADDR_W  address of the presented instruction.
REQ-016 inst_data  output  INST_W  presented instruction.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, OUT; encoding is free.
REQ-018 Registers SHALL be: state, pc (ADDR_W), drop (1 bit), inst_valid, inst_addr, inst_data; all outputs are driven from registers or directly from state/pc.
REQ-019 IDLE SHALL last exactly one cycle after reset release, then move to REQ.
REQ-020 mem_req_valid SHALL be 1 only in REQ; mem_req_addr SHALL equal pc at all times.
REQ-021 REQ with mem_req_ready=1 SHALL move to WAIT (handshake); with mem_req_ready=0 SHALL stay in REQ.
REQ-022 Only one request SHALL ever be outstanding; no new request until the response arrives.
REQ-023 WAIT with mem_rsp_valid=1 and drop=0 SHALL load inst_data<=mem_rsp_data, inst_addr<=pc, pc<=pc+4 (modulo 2^ADDR_W), inst_valid<=1, state<=OUT.
REQ-024 OUT with stall=0 SHALL clear inst_valid and move to REQ; with stall=1 SHALL hold all outputs unchanged.
REQ-025 mem_rsp_valid outside WAIT SHALL be ignored with no state change.
REQ-026 Redirect SHALL take priority over stall and over response capture; on redirect_valid=1, pc<=redirect_pc in every state except IDLE, where the redirect is ignored.
REQ-027 Redirect in REQ without handshake: stay in REQ; the next cycle presents redirect_pc.
REQ-028 Redirect in REQ with handshake in the same cycle: move to WAIT with drop<=1.
REQ-029 Redirect in WAIT without response: set drop<=1 and stay in WAIT.
REQ-030 Redirect in WAIT with a same-cycle response: discard the response, clear drop, move to REQ, keep inst_valid at 0.
REQ-031 WAIT with mem_rsp_valid=1 and drop=1 (no new redirect): discard the response, clear drop, move to REQ.
REQ-032 Redirect in OUT: clear inst_valid next cycle regardless of stall, then move to REQ.
REQ-033 Throughput SHALL be one instruction per 3 cycles minimum (REQ, WAIT, OUT), with zero-wait memory and no stall.

Reset
REQ-034 While rst_n=0: state=IDLE, pc=RESET_PC, drop=0, inst_valid=0, inst_addr=0, inst_data=0, mem_req_valid=0; asserted asynchronously.
REQ-035 Reset mid-operation SHALL abandon any outstanding request; stray responses after release are ignored per REQ-025.

Verification
REQ-036 Reset release, ready=1, rsp one cycle after each handshake with data 0x13, stall=0 -> requests at 0x0, 0x4, 0x8; inst_valid pulses with inst_addr 0x0, 0x4, 0x8 every 3 cycles.
REQ-037 stall=1 for 4 cycles while in OUT with inst_addr=0x4 -> inst_valid, inst_addr, inst_data held; no mem_req_valid until stall drops.
REQ-038 Redirect to 0x100 while in WAIT for 0x8; rsp arrives 2 cycles later -> response discarded, inst_valid stays 0, next request addr 0x100.
REQ-039 Redirect to 0x200 in the same cycle as a WAIT response -> no inst_valid; next request addr 0x200.
REQ-040 mem_req_ready=0 for 3 cycles, then redirect to 0x40, then ready=1 -> mem_req_valid held high throughout, address switches to 0x40, handshake at 0x40.
REQ-041 pc=2^64-4, fetch completes -> inst_addr=0xFFFF_FFFF_FFFF_FFFC, next request addr 0x0; rst_n pulsed low mid-WAIT -> outputs at reset values immediately, restart at RESET_PC.
